// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequences C = A x B (NxN, unsigned) through one shared MAC.
// Walks (i,j,k) in row-major order, reads A/B with 1-cycle latency, writes C.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle request, accepted only in IDLE
//   busy, done     busy from first RUN cycle through DONE; done one-cycle pulse
//   rd_en          read strobe to the A and B buffers
//   a_addr, b_addr operand addresses i*N+k and k*N+j
//   a_data, b_data operand read data, valid the cycle after rd_en
//   c_we, c_addr   result write strobe and address i*N+j
//   c_data         finished element sum (0 whenever c_we is low)
module matmul_seq_ctrl #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = (N > 1) ? $clog2(N * N) : 1,
    parameter int CW = 2 * DW + $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    input  logic [DW-1:0] a_data,
    input  logic [DW-1:0] b_data,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [CW-1:0] c_data
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] i, j, k;
    logic [CW-1:0] acc;
    logic          v1;

    logic [CW-1:0] prod;
    logic [CW-1:0] acc_sum;
    logic [IW-1:0] ni, nj, nk;
    logic          last_elem;

    function automatic logic [AW-1:0] addr_of(
        input logic [IW-1:0] r,
        input logic [IW-1:0] c
    );
        return AW'(32'(r) * N + 32'(c));
    endfunction

    assign prod    = CW'(a_data) * CW'(b_data);
    assign acc_sum = acc + prod;

    // Index that follows the element currently being written.
    always_comb begin
        nk        = k + IW'(1);
        last_elem = (i == LAST) && (j == LAST);
        nj        = j + IW'(1);
        ni        = i;
        if (j == LAST) begin
            nj = '0;
            ni = (i == LAST) ? '0 : i + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            acc    <= '0;
            v1     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            rd_en  <= 1'b0;
            a_addr <= '0;
            b_addr <= '0;
            c_we   <= 1'b0;
            c_addr <= '0;
            c_data <= '0;
        end else begin
            // Read data lands one cycle after the strobe.
            v1 <= rd_en;
            if (v1) begin
                acc <= acc_sum;
            end

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        i      <= '0;
                        j      <= '0;
                        k      <= '0;
                        acc    <= '0;
                        busy   <= 1'b1;
                        rd_en  <= 1'b1;
                        a_addr <= '0;
                        b_addr <= '0;
                    end
                end

                S_RUN: begin
                    if (k == LAST) begin
                        k     <= '0;
                        rd_en <= 1'b0;
                        state <= S_DRAIN;
                    end else begin
                        k      <= nk;
                        a_addr <= addr_of(i, nk);
                        b_addr <= addr_of(nk, j);
                    end
                end

                // The last product is folded in at this edge, so the
                // registered c_data already carries the complete sum.
                S_DRAIN: begin
                    state  <= S_WRITE;
                    c_we   <= 1'b1;
                    c_addr <= addr_of(i, j);
                    c_data <= v1 ? acc_sum : acc;
                end

                S_WRITE: begin
                    acc    <= '0;
                    i      <= ni;
                    j      <= nj;
                    c_we   <= 1'b0;
                    c_data <= '0;
                    if (last_elem) begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        a_addr <= '0;
                        b_addr <= '0;
                        c_addr <= '0;
                    end else begin
                        state  <= S_RUN;
                        rd_en  <= 1'b1;
                        a_addr <= addr_of(ni, '0);
                        b_addr <= addr_of('0, nj);
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: scoreboard bench for matmul_seq_ctrl (N=4 and N=1 builds).
// A reference product computed with plain loops feeds read/write queues.
module tb_matmul_seq_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CW = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, rd_en, c_we;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic [DW-1:0] a_data, b_data;
    logic [CW-1:0] c_data;

    logic          start1;
    logic          busy1, done1, rd_en1, c_we1;
    logic [0:0]    a_addr1, b_addr1, c_addr1;
    logic [DW-1:0] a_data1, b_data1;
    logic [15:0]   c_data1;

    always #5 clk = ~clk;

    matmul_seq_ctrl #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .rd_en(rd_en),
        .a_addr(a_addr), .b_addr(b_addr),
        .a_data(a_data), .b_data(b_data),
        .c_we(c_we), .c_addr(c_addr), .c_data(c_data)
    );

    matmul_seq_ctrl #(.N(1), .DW(DW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .busy(busy1), .done(done1), .rd_en(rd_en1),
        .a_addr(a_addr1), .b_addr(b_addr1),
        .a_data(a_data1), .b_data(b_data1),
        .c_we(c_we1), .c_addr(c_addr1), .c_data(c_data1)
    );

    assign a_data1 = 8'd200;
    assign b_data1 = 8'd100;

    int A [N*N];
    int B [N*N];

    typedef struct { int a; int b; } rd_t;
    typedef struct { int addr; int data; } wr_t;
    rd_t rq[$];
    wr_t wq[$];

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Operand buffers with a fixed one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= DW'(A[a_addr]);
            b_data <= DW'(B[b_addr]);
        end
    end

    rd_t mr;
    wr_t mw;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                if (rq.size() == 0) begin
                    chk("extra_read", 1, 0);
                end else begin
                    mr = rq.pop_front();
                    chk("a_addr", a_addr, mr.a);
                    chk("b_addr", b_addr, mr.b);
                end
            end
            if (c_we) begin
                if (wq.size() == 0) begin
                    chk("extra_write", 1, 0);
                end else begin
                    mw = wq.pop_front();
                    chk("c_addr", c_addr, mw.addr);
                    chk("c_data", c_data, mw.data);
                end
            end else begin
                chk("c_data_idle", c_data, 0);
            end
        end
    end

    task automatic expect_product();
        int sum;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                sum = 0;
                for (int x = 0; x < N; x++) begin
                    sum += A[r*N+x] * B[x*N+c];
                    rq.push_back('{a: r*N+x, b: x*N+c});
                end
                wq.push_back('{addr: r*N+c, data: sum});
            end
        end
    endtask

    // Called at a negedge; raises start right away so back-to-back
    // runs can hit the first IDLE cycle after DONE.
    task automatic run(input int p1, input int p2, input bit pdone);
        int cyc;
        bit got;
        expect_product();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_run", busy, 1);
        cyc = 0;
        got = 1'b0;
        while (cyc < 300) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (cyc == p1 || cyc == p2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("done_latency", got ? cyc : -1, N * N * (N + 2));
        chk("busy_done", busy, 1);
        if (pdone) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after", busy, 0);
        chk("done_pulse", done, 0);
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
    endtask

    task automatic fill_random();
        for (int x = 0; x < N*N; x++) begin
            A[x] = int'($urandom_range(0, 255));
            B[x] = int'($urandom_range(0, 255));
        end
    endtask

    initial begin
        int cyc;
        int nw;
        int w_addr;
        int w_data;

        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        for (int x = 0; x < N*N; x++) begin
            A[x] = 0;
            B[x] = 0;
        end
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_outs", {done, rd_en, c_we, a_addr, b_addr, c_addr, c_data}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rd_en", rd_en, 0);

        // Identity times a counting matrix.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                A[r*N+c] = (r == c) ? 1 : 0;
                B[r*N+c] = r * 4 + c;
            end
        run(-1, -1, 1'b0);

        // Saturated operands exercise the full accumulator width.
        for (int x = 0; x < N*N; x++) begin
            A[x] = 255;
            B[x] = 255;
        end
        run(-1, -1, 1'b0);

        // Rank-one style product: C[i][j] = 4*(i+1)*(j+1).
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                A[r*N+c] = r + 1;
                B[r*N+c] = c + 1;
            end
        run(-1, -1, 1'b0);

        // Stray starts while busy and in DONE, then restart right away.
        fill_random();
        run(10, 50, 1'b1);
        run(-1, -1, 1'b0);

        // Reset during element 5 (i=1, j=1) with k=2 on the bus.
        fill_random();
        expect_product();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        chk("pre_rst_a", a_addr, 6);
        chk("pre_rst_b", b_addr, 9);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_outs", {done, rd_en, c_we, a_addr, b_addr, c_addr, c_data}, 0);
        rq.delete();
        wq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        nw = 0;
        repeat (20) begin
            @(negedge clk);
            if (c_we || rd_en || done) nw++;
        end
        chk("post_rst_quiet", nw, 0);
        run(-1, -1, 1'b0);

        fill_random();
        run(-1, -1, 1'b0);

        // N=1 build: one element, done three cycles after acceptance.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0;
        nw = 0;
        w_addr = -1;
        w_data = -1;
        while (cyc < 20) begin
            if (c_we1) begin
                nw++;
                w_addr = int'(c_addr1);
                w_data = int'(c_data1);
            end
            if (done1) break;
            @(negedge clk);
            cyc++;
        end
        chk("n1_latency", cyc, 3);
        chk("n1_writes", nw, 1);
        chk("n1_addr", w_addr, 0);
        chk("n1_data", w_data, 20000);
        @(negedge clk);
        chk("n1_busy_after", busy1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
